rand_lane_packer: RTL and testbench

//  Parametrised lane-to-AXI-Stream packer for the random-block generators. Takes NUM_LANES parallel

---
 rtl/rand_lane_packer_pkg.sv | 23 ++
 rtl/rand_lane_packer_if.sv | 26 ++
 rtl/rand_lane_packer_compactor.sv | 28 ++
 rtl/rand_lane_packer.sv | 197 +++++++++++++++++++
 tb/tb_rand_lane_packer.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rand_lane_packer_pkg.sv
// Shared types and size helpers for the lane-to-AXIS packer.
package rand_pack_pkg;

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    FLUSH = 1'b1
  } pack_state_t;

  function automatic int calc_out_blocks(input int out_bytes, input int block_size);
    return (out_bytes * 8) / block_size;
  endfunction

  function automatic int calc_acc_blocks(input int out_bytes, input int block_size,
                                         input int num_lanes);
    return calc_out_blocks(out_bytes, block_size) + num_lanes - 1;
  endfunction

  // Width of a counter able to hold 0..max_val inclusive.
  function automatic int calc_cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rand_lane_packer_if.sv
// Lane input bus and AXIS output bus of the packer, with driver (master) and packer (slave) views.
interface rand_lane_packer_if #(
  parameter int NUM_LANES  = 8,
  parameter int BLOCK_SIZE = 128,
  parameter int OUT_BYTES  = 128
);
  logic [NUM_LANES-1:0]            in_valid;
  logic [NUM_LANES*BLOCK_SIZE-1:0] in_data;
  logic [NUM_LANES-1:0]            in_last;
  logic [NUM_LANES-1:0]            in_ready;
  logic [OUT_BYTES*8-1:0]          out_data;
  logic [OUT_BYTES-1:0]            out_keep;
  logic                            out_valid;
  logic                            out_last;
  logic                            out_ready;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_data, out_keep, out_valid, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_data, out_keep, out_valid, out_last
  );
endinterface

// File: rtl/rand_lane_packer_compactor.sv
// rand_lane_compactor: packs the blocks of set mask bits densely, lowest lane first, and counts them.
module rand_lane_compactor #(
  parameter int NUM_LANES  = 8,
  parameter int BLOCK_SIZE = 128,
  parameter int LCW        = 4
) (
  input  logic [NUM_LANES-1:0]            mask_i,
  input  logic [NUM_LANES*BLOCK_SIZE-1:0] data_i,
  output logic [NUM_LANES*BLOCK_SIZE-1:0] data_o,
  output logic [LCW-1:0]                  count_o
);
  logic [LCW-1:0] run_s;

  // run_s is the exclusive prefix popcount: the dense slot of lane i.
  always_comb begin
    run_s  = '0;
    data_o = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (mask_i[i]) begin
        data_o[run_s*BLOCK_SIZE +: BLOCK_SIZE] = data_i[i*BLOCK_SIZE +: BLOCK_SIZE];
        run_s = run_s + LCW'(1);
      end else begin
        run_s = run_s;
      end
    end
    count_o = run_s;
  end
endmodule

// File: rtl/rand_lane_packer.sv
// rand_lane_packer: compacts valid generator lanes into dense AXIS beats with byte keep.
// Defining RAND_PACK_STATS_EN adds the stat_beats/stat_frames handshake counters.
module rand_lane_packer
  import rand_pack_pkg::*;
#(
  parameter int NUM_LANES  = 8,
  parameter int BLOCK_SIZE = 128,
  parameter int OUT_BYTES  = 128
) (
  input logic               clk,
  input logic               rst,
  rand_lane_packer_if.slave bus
`ifdef RAND_PACK_STATS_EN
  ,
  output logic [31:0]       stat_beats,
  output logic [31:0]       stat_frames
`endif
);
  localparam int BLK_BYTES  = BLOCK_SIZE / 8;
  localparam int OUT_BLOCKS = calc_out_blocks(OUT_BYTES, BLOCK_SIZE);
  localparam int ACC_BLOCKS = calc_acc_blocks(OUT_BYTES, BLOCK_SIZE, NUM_LANES);
  localparam int CNT_W      = calc_cnt_width(ACC_BLOCKS);
  localparam int LCW        = calc_cnt_width(NUM_LANES);
  localparam int OUT_W      = OUT_BYTES * 8;

  typedef logic [CNT_W-1:0] count_t;
  localparam count_t OUT_BLOCKS_C = count_t'(OUT_BLOCKS);

  pack_state_t              state_q, state_d;
  count_t                   count_q, count_d;
  logic [BLOCK_SIZE-1:0]    acc_q [ACC_BLOCKS];
  logic [BLOCK_SIZE-1:0]    acc_d [ACC_BLOCKS];
  logic [OUT_W-1:0]         out_data_q, out_data_d;
  logic [OUT_BYTES-1:0]     out_keep_q, out_keep_d;
  logic                     out_valid_q, out_valid_d;
  logic                     out_last_q, out_last_d;
  logic                     in_ready_q, in_ready_d;

  logic [NUM_LANES-1:0]            acc_mask_s;
  logic                            any_last_s;
  logic [NUM_LANES*BLOCK_SIZE-1:0] comp_data_s;
  logic [LCW-1:0]                  comp_cnt_s;
  logic                            free_s;
  logic                            emit_full_s;
  logic                            emit_final_s;
  count_t                          emit_cnt_s;
  count_t                          base_s;

  assign acc_mask_s = bus.in_valid & {NUM_LANES{in_ready_q}};
  assign any_last_s = |(acc_mask_s & bus.in_last);

  rand_lane_compactor #(
    .NUM_LANES  (NUM_LANES),
    .BLOCK_SIZE (BLOCK_SIZE),
    .LCW        (LCW)
  ) u_compactor (
    .mask_i  (acc_mask_s),
    .data_i  (bus.in_data),
    .data_o  (comp_data_s),
    .count_o (comp_cnt_s)
  );

  // Next-state: emit decision, accumulator shift/append, FSM and output register.
  always_comb begin
    state_d      = state_q;
    out_data_d   = out_data_q;
    out_keep_d   = out_keep_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    free_s       = !out_valid_q || bus.out_ready;
    emit_full_s  = 1'b0;
    emit_final_s = 1'b0;

    case (state_q)
      FILL: emit_full_s = free_s && (count_q >= OUT_BLOCKS_C);
      FLUSH: begin
        if (count_q > OUT_BLOCKS_C) begin
          emit_full_s = free_s;
        end else begin
          emit_final_s = free_s && (count_q != count_t'(0));
        end
      end
      default: emit_full_s = 1'b0;
    endcase

    emit_cnt_s = emit_full_s ? OUT_BLOCKS_C : (emit_final_s ? count_q : count_t'(0));
    base_s     = count_q - emit_cnt_s;

    if (emit_full_s || emit_final_s) begin
      out_valid_d = 1'b1;
      out_last_d  = emit_final_s;
      for (int j = 0; j < OUT_BLOCKS; j++) begin
        if (emit_full_s || (count_t'(j) < count_q)) begin
          out_data_d[j*BLOCK_SIZE +: BLOCK_SIZE] = acc_q[j];
          out_keep_d[j*BLK_BYTES +: BLK_BYTES]   = '1;
        end else begin
          out_data_d[j*BLOCK_SIZE +: BLOCK_SIZE] = '0;
          out_keep_d[j*BLK_BYTES +: BLK_BYTES]   = '0;
        end
      end
      for (int j = 0; j < ACC_BLOCKS; j++) begin
        acc_d[j] = ((j + OUT_BLOCKS) < ACC_BLOCKS) ? acc_q[(j + OUT_BLOCKS) % ACC_BLOCKS] : '0;
      end
    end else if (free_s) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      for (int j = 0; j < ACC_BLOCKS; j++) begin
        acc_d[j] = acc_q[j];
      end
    end else begin
      for (int j = 0; j < ACC_BLOCKS; j++) begin
        acc_d[j] = acc_q[j];
      end
    end

    // New blocks land right after whatever survives this cycle's emit.
    for (int j = 0; j < ACC_BLOCKS; j++) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        acc_d[j] = ((LCW'(k) < comp_cnt_s) && (count_t'(j) == base_s + count_t'(k)))
                   ? comp_data_s[k*BLOCK_SIZE +: BLOCK_SIZE] : acc_d[j];
      end
    end
    count_d = base_s + count_t'(comp_cnt_s);

    case (state_q)
      FILL:    state_d = any_last_s ? FLUSH : FILL;
      FLUSH:   state_d = (emit_final_s || (count_q == count_t'(0))) ? FILL : FLUSH;
      default: state_d = FILL;
    endcase

    in_ready_d = (state_d == FILL) && (count_d < OUT_BLOCKS_C);
  end

  // State, accumulator and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FILL;
      count_q     <= '0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      for (int j = 0; j < ACC_BLOCKS; j++) begin
        acc_q[j] <= '0;
      end
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      in_ready_q  <= in_ready_d;
      for (int j = 0; j < ACC_BLOCKS; j++) begin
        acc_q[j] <= acc_d[j];
      end
    end
  end

  assign bus.in_ready  = {NUM_LANES{in_ready_q}};
  assign bus.out_data  = out_data_q;
  assign bus.out_keep  = out_keep_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;

`ifdef RAND_PACK_STATS_EN
  logic [31:0] stat_beats_q, stat_beats_d;
  logic [31:0] stat_frames_q, stat_frames_d;

  // Handshake counters; wrap naturally at 2^32.
  always_comb begin
    if (out_valid_q && bus.out_ready) begin
      stat_beats_d  = stat_beats_q + 32'd1;
      stat_frames_d = out_last_q ? (stat_frames_q + 32'd1) : stat_frames_q;
    end else begin
      stat_beats_d  = stat_beats_q;
      stat_frames_d = stat_frames_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_beats_q  <= 32'd0;
      stat_frames_q <= 32'd0;
    end else begin
      stat_beats_q  <= stat_beats_d;
      stat_frames_q <= stat_frames_d;
    end
  end

  assign stat_beats  = stat_beats_q;
  assign stat_frames = stat_frames_q;
`endif

endmodule

// File: tb/tb_rand_lane_packer.sv
// Directed bench for rand_lane_packer: queue-based beat model checked on every handshake,
// plus literal expectations per scenario. Stats scenario runs when RAND_PACK_STATS_EN is defined.
module tb_rand_lane_packer;
  localparam int NL    = 8;
  localparam int BS    = 128;
  localparam int OB    = 128;
  localparam int OUT_W = OB * 8;
  localparam int OBLK  = 8;
  localparam int BB    = 16;

  typedef struct {
    logic [OUT_W-1:0] data;
    logic [OB-1:0]    keep;
    logic             last;
  } beat_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   model_beats;

  beat_t             exp_q[$];
  beat_t             cap_q[$];
  logic [BS-1:0]     pend_q[$];
  beat_t             e;
  beat_t             cur;
  logic              stall_prev;
  logic [OUT_W-1:0]  prev_data;
  logic [OB-1:0]     prev_keep;
  logic              prev_last;
  logic [NL-1:0]     accepted;
  int                bad;

  rand_lane_packer_if #(.NUM_LANES(NL), .BLOCK_SIZE(BS), .OUT_BYTES(OB)) bus ();

`ifdef RAND_PACK_STATS_EN
  logic [31:0] stat_beats;
  logic [31:0] stat_frames;
`endif

  rand_lane_packer #(.NUM_LANES(NL), .BLOCK_SIZE(BS), .OUT_BYTES(OB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef RAND_PACK_STATS_EN
    ,
    .stat_beats  (stat_beats),
    .stat_frames (stat_frames)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [BS-1:0] blk(input int tag, input int lane);
    logic [BS-1:0] b;
    b = '0;
    b[31:0] = 32'(lane);
    b[BS-1:BS-32] = 32'(tag);
    return b;
  endfunction

  function automatic logic [BS-1:0] cap_blk(input int beat, input int k);
    return cap_q[beat].data[k*BS +: BS];
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Frames are cut into 8-block beats; the frame's tail (possibly a full beat) carries last.
  task automatic model_build(input bit last);
    beat_t b;
    while ((pend_q.size() >= OBLK) || (last && pend_q.size() > 0)) begin
      b.data = '0;
      b.keep = '0;
      for (int k = 0; k < OBLK; k++) begin
        if (pend_q.size() > 0) begin
          b.data[k*BS +: BS] = pend_q.pop_front();
          b.keep[k*BB +: BB] = '1;
        end
      end
      b.last = last && (pend_q.size() == 0);
      exp_q.push_back(b);
      model_beats++;
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      pend_q.delete();
      stall_prev = 1'b0;
    end else begin
      checks++;
      if (bus.in_ready != '0 && bus.in_ready != '1) begin
        failures++;
        $display("FAIL in_ready_uniform got=%b want=all-equal", bus.in_ready);
      end
      if (stall_prev) begin
        checks++;
        if (!bus.out_valid || bus.out_data !== prev_data || bus.out_keep !== prev_keep ||
            bus.out_last !== prev_last) begin
          failures++;
          $display("FAIL hold_stable got valid=%b keep=%h last=%b want valid=1 keep=%h last=%b",
                   bus.out_valid, bus.out_keep, bus.out_last, prev_keep, prev_last);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        cur.data = bus.out_data;
        cur.keep = bus.out_keep;
        cur.last = bus.out_last;
        cap_q.push_back(cur);
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_beat got keep=%h last=%b want no beat", cur.keep, cur.last);
        end else begin
          e = exp_q.pop_front();
          if (cur.data !== e.data || cur.keep !== e.keep || cur.last !== e.last) begin
            bad = 0;
            for (int k = OBLK - 1; k >= 0; k--) begin
              if (cur.data[k*BS +: BS] !== e.data[k*BS +: BS]) bad = k;
            end
            failures++;
            $display("FAIL beat_compare blk=%0d got data=%h keep=%h last=%b want data=%h keep=%h last=%b",
                     bad, cur.data[bad*BS +: BS], cur.keep, cur.last,
                     e.data[bad*BS +: BS], e.keep, e.last);
          end
        end
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_keep  = bus.out_keep;
      prev_last  = bus.out_last;
      accepted = bus.in_valid & bus.in_ready;
      if (accepted != '0) begin
        for (int i = 0; i < NL; i++) begin
          if (accepted[i]) pend_q.push_back(bus.in_data[i*BS +: BS]);
        end
        model_build(|(accepted & bus.in_last));
      end
    end
  end

  task automatic set_in(input logic [NL-1:0] mask, input int tag, input bit last);
    bus.in_valid = mask;
    bus.in_last  = last ? mask : ~mask;
    for (int i = 0; i < NL; i++) bus.in_data[i*BS +: BS] = blk(tag, i);
  endtask

  task automatic clear_in();
    bus.in_valid = '0;
    bus.in_last  = '0;
    bus.in_data  = '0;
  endtask

  // Hold one lane vector until accepted, then return at posedge+1 with inputs idle.
  task automatic send(input logic [NL-1:0] mask, input int tag, input bit last);
    bit got;
    got = 1'b0;
    set_in(mask, tag, last);
    for (int w = 0; w < 100 && !got; w++) begin
      @(negedge clk);
      got = bus.in_ready[0];
      if (!got) begin
        @(posedge clk);
        #1;
      end
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL send_timeout tag=%0d got in_ready=0 want 1", tag);
    end else begin
      @(posedge clk);
      #1;
    end
    clear_in();
  endtask

  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    for (int w = 0; w < 300 && !done; w++) begin
      @(posedge clk);
      #1;
      done = (exp_q.size() == 0) && !bus.out_valid;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s_drain_timeout got pending=%0d want 0", name, exp_q.size());
    end
  endtask

  initial begin
    int start;
    int mb0;
    int lanes2[8];
    checks      = 0;
    failures    = 0;
    model_beats = 0;
    stall_prev  = 1'b0;
    lanes2      = '{0, 2, 5, 7, 0, 2, 5, 7};
    bus.out_ready = 1'b1;
    clear_in();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("rst_out_last",  128'(bus.out_last),  128'd0);
    chk("rst_out_keep",  bus.out_keep,        128'd0);
    chk("rst_out_data",  bus.out_data[127:0], 128'd0);
    chk("rst_in_ready",  128'(bus.in_ready),  128'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 128'(bus.in_ready), 128'hFF);

    // 1: four full vectors, last on the fourth
    start = cap_q.size();
    mb0   = model_beats;
    for (int c = 0; c < 4; c++) send('1, 10 + c, c == 3);
    drain("t1");
    chk("t1_beats", 128'(cap_q.size() - start), 128'd4);
    chk("t1_model_beats", 128'(model_beats - mb0), 128'd4);
    if (cap_q.size() - start == 4) begin
      for (int b = 0; b < 4; b++) begin
        chk($sformatf("t1_last%0d", b), 128'(cap_q[start+b].last), 128'(b == 3));
        chk($sformatf("t1_keep%0d", b), cap_q[start+b].keep, {128{1'b1}});
      end
      chk("t1_b0_blk0", cap_blk(start, 0), blk(10, 0));
      chk("t1_b3_blk7", cap_blk(start + 3, 7), blk(13, 7));
    end

    // 2: idle cycles with stray last, then sparse mask
    bus.in_valid = '0;
    bus.in_last  = '1;
    repeat (3) @(posedge clk);
    #1;
    clear_in();
    start = cap_q.size();
    mb0   = model_beats;
    send(8'b1010_0101, 0, 1'b0);
    send(8'b1010_0101, 0, 1'b1);
    drain("t2");
    chk("t2_beats", 128'(cap_q.size() - start), 128'd1);
    chk("t2_model_beats", 128'(model_beats - mb0), 128'd1);
    if (cap_q.size() - start == 1) begin
      for (int k = 0; k < 8; k++) chk($sformatf("t2_blk%0d", k), cap_blk(start, k), 128'(lanes2[k]));
      chk("t2_keep", cap_q[start].keep, {128{1'b1}});
      chk("t2_last", 128'(cap_q[start].last), 128'd1);
    end

    // 3: short frame, partial keep
    start = cap_q.size();
    send(8'b0000_0111, 5, 1'b1);
    drain("t3");
    chk("t3_beats", 128'(cap_q.size() - start), 128'd1);
    if (cap_q.size() - start == 1) begin
      chk("t3_keep", cap_q[start].keep, {80'h0, 48'hFFFF_FFFF_FFFF});
      chk("t3_last", 128'(cap_q[start].last), 128'd1);
      chk("t3_blk2", cap_blk(start, 2), blk(5, 2));
      checks++;
      if (cap_q[start].data[OUT_W-1:3*BS] !== '0) begin
        failures++;
        $display("FAIL t3_upper_data got=%h want=0", cap_q[start].data[4*BS-1:3*BS]);
      end
    end

    // 4: downstream stall under continuous input
    start = cap_q.size();
    bus.out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      set_in('1, 20 + c, 1'b0);
      @(posedge clk);
      #1;
    end
    clear_in();
    chk("t4_in_ready_stalled", 128'(bus.in_ready), 128'd0);
    chk("t4_out_valid_stalled", 128'(bus.out_valid), 128'd1);
    bus.out_ready = 1'b1;
    send('1, 40, 1'b0);
    send('1, 41, 1'b1);
    drain("t4");
    chk("t4_beats", 128'(cap_q.size() - start), 128'd4);
    if (cap_q.size() - start == 4) begin
      chk("t4_b0", cap_blk(start, 0), blk(20, 0));
      chk("t4_b1", cap_blk(start + 1, 0), blk(22, 0));
      chk("t4_b2", cap_blk(start + 2, 0), blk(40, 0));
      chk("t4_b3", cap_blk(start + 3, 7), blk(41, 7));
      chk("t4_last3", 128'(cap_q[start+3].last), 128'd1);
      chk("t4_last1", 128'(cap_q[start+1].last), 128'd0);
    end

    // 5: reset mid-frame with a stalled beat and 5 buffered blocks
    bus.out_ready = 1'b0;
    send('1, 50, 1'b0);
    send(8'b0001_1111, 51, 1'b0);
    @(posedge clk);
    #1;
    chk("t5_pre_rst_valid", 128'(bus.out_valid), 128'd1);
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", 128'(bus.out_valid), 128'd0);
    chk("t5_rst_keep", bus.out_keep, 128'd0);
    chk("t5_rst_in_ready", 128'(bus.in_ready), 128'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    start = cap_q.size();
    send(8'b0000_0011, 60, 1'b1);
    drain("t5");
    chk("t5_beats", 128'(cap_q.size() - start), 128'd1);
    if (cap_q.size() - start == 1) begin
      chk("t5_blk0", cap_blk(start, 0), blk(60, 0));
      chk("t5_keep", cap_q[start].keep, {96'h0, 32'hFFFF_FFFF});
      chk("t5_last", 128'(cap_q[start].last), 128'd1);
    end

`ifdef RAND_PACK_STATS_EN
    // 6: three two-beat frames counted after a fresh reset
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int f = 0; f < 3; f++) begin
      send('1, 70 + 2 * f, 1'b0);
      send('1, 71 + 2 * f, 1'b1);
    end
    drain("t6");
    chk("t6_stat_beats", 128'(stat_beats), 128'd6);
    chk("t6_stat_frames", 128'(stat_frames), 128'd3);
`endif

    chk("end_model_empty", 128'(exp_q.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
